operand2_shift_pipe: RTL

OPERAND2_SHIFT_PIPE -- requirements
Module: operand2_shift_pipe

---
 rtl/operand2_shift_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/operand2_shift_pipe.sv
// Two-stage operand-2 shifter: stage 1 decodes amount/type/operand, stage 2 shifts.
// Optional build macro SHIFT_RRX_EN turns immediate ROR #0 into RRX.
module operand2_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [1:0]       sh,
  input  logic [11:0]      imm,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rm,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] src2,
  output logic             carry_out
);

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and data is held while valid && !ready.
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_op;
  logic [7:0]       r_s1_amt;
  logic [1:0]       r_s1_sh;
  logic             r_s1_cin;
  logic             r_s1_rrx;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_src2;
  logic             r_s2_carry;

  logic             w_s1_ready;
  logic             w_s2_ready;
  logic [WIDTH-1:0] w_d_op;
  logic [7:0]       w_d_amt;
  logic [1:0]       w_d_sh;
  logic             w_d_rrx;
  logic [WIDTH:0]   w_lsl;
  logic [WIDTH:0]   w_lsr;
  logic signed [WIDTH:0] w_asr;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_unused;

  assign w_s2_ready = !r_s2_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready;
  assign out_valid  = r_s2_valid;
  assign src2       = r_s2_src2;
  assign carry_out  = r_s2_carry;
  assign w_unused   = ^rs;

  // Every source is normalised to a register-style shift: amount 0 means pass rm
  // with carry_in, and immediate LSR/ASR #0 become a shift by exactly WIDTH.
  always_comb begin
    w_d_op  = rm;
    w_d_amt = 8'd0;
    w_d_sh  = sh;
    w_d_rrx = 1'b0;
    case (mode)
      2'd0: begin
        w_d_op  = WIDTH'(imm[7:0]);
        w_d_amt = 8'({imm[11:8], 1'b0});
        w_d_sh  = SH_ROR;
      end
      2'd1: begin
        if (imm[SHW-1:0] != '0) begin
          w_d_amt = 8'(imm[SHW-1:0]);
        end else begin
          case (sh)
            SH_LSR, SH_ASR: w_d_amt = 8'(WIDTH);
`ifdef SHIFT_RRX_EN
            SH_ROR:         w_d_rrx = 1'b1;
`endif
            default:        w_d_amt = 8'd0;
          endcase
        end
      end
      2'd2:    w_d_amt = rs[7:0];
      default: w_d_amt = 8'd0;
    endcase
  end

  // One extra bit beside the operand catches the last bit shifted out.
  assign w_lsl = {1'b0, r_s1_op} << r_s1_amt;
  assign w_lsr = {r_s1_op, 1'b0} >> r_s1_amt;
  assign w_asr = $signed({r_s1_op, 1'b0}) >>> r_s1_amt;
  assign w_ror = WIDTH'({r_s1_op, r_s1_op} >> r_s1_amt[SHW-1:0]);

  always_comb begin
    w_res   = r_s1_op;
    w_carry = r_s1_cin;
    if (r_s1_rrx) begin
      w_res   = {r_s1_cin, r_s1_op[WIDTH-1:1]};
      w_carry = r_s1_op[0];
    end else if (r_s1_amt != 8'd0) begin
      case (r_s1_sh)
        SH_LSL: begin
          w_res   = w_lsl[WIDTH-1:0];
          w_carry = w_lsl[WIDTH];
        end
        SH_LSR: begin
          w_res   = w_lsr[WIDTH:1];
          w_carry = w_lsr[0];
        end
        SH_ASR: begin
          w_res   = w_asr[WIDTH:1];
          w_carry = w_asr[0];
        end
        default: begin
          w_res   = w_ror;
          w_carry = w_ror[WIDTH-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_amt   <= 8'd0;
      r_s1_sh    <= 2'd0;
      r_s1_cin   <= 1'b0;
      r_s1_rrx   <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op  <= w_d_op;
        r_s1_amt <= w_d_amt;
        r_s1_sh  <= w_d_sh;
        r_s1_cin <= carry_in;
        r_s1_rrx <= w_d_rrx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_src2  <= '0;
      r_s2_carry <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_src2  <= w_res;
        r_s2_carry <= w_carry;
      end
    end
  end

endmodule
